// File: rtl/vgacpu_pkg.sv
// Shared framebuffer geometry, pixel/address types and the line-engine state enum
// used by the rasterizer primitives.
package vgacpu_pkg;

  localparam int FB_WIDTH    = 214;
  localparam int FB_HEIGHT   = 160;
  localparam int FB_A_WIDTH  = 16;
  localparam int PIXEL_WIDTH = 3;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;
  typedef logic [FB_A_WIDTH-1:0]  fb_addr_t;
  typedef logic [7:0]             coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } line_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational framebuffer address y*214 + x built from shifts and adds
// (214 = 128+64+16+4+2); result wraps modulo 2^16 for out-of-range points.
module fb_addr_calc
  import vgacpu_pkg::*;
(
  input  logic signed [8:0] x_i,
  input  logic signed [8:0] y_i,
  output fb_addr_t          addr_o
);

  logic [15:0] x_ext;
  logic [15:0] y_ext;

  always_comb begin
    x_ext  = {{7{x_i[8]}}, x_i};
    y_ext  = {{7{y_i[8]}}, y_i};
    addr_o = (y_ext << 7) + (y_ext << 6) + (y_ext << 4) + (y_ext << 2) + (y_ext << 1) + x_ext;
  end

endmodule

// File: rtl/fb_line_drawer.sv
// Bresenham line engine driving the framebuffer write port, one pixel per cycle.
// Define FB_LINE_DRAWER_CLIP_EN to suppress writes for off-screen points.
module fb_line_drawer #(
  parameter int FB_WIDTH  = vgacpu_pkg::FB_WIDTH,
  parameter int FB_HEIGHT = vgacpu_pkg::FB_HEIGHT,
  parameter int A_WIDTH   = vgacpu_pkg::FB_A_WIDTH,
  parameter int D_WIDTH   = vgacpu_pkg::PIXEL_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_async,
  input  logic                    start,
  input  logic [7:0]              x0,
  input  logic [7:0]              y0,
  input  logic [7:0]              x1,
  input  logic [7:0]              y1,
  input  logic [D_WIDTH-1:0]      colour,
  output logic                    busy,
  output logic                    done,
  output logic [A_WIDTH-1:0]      fb_addr,
  output logic                    fb_write_en,
  output logic [D_WIDTH-1:0]      fb_pixel,
  output vgacpu_pkg::line_state_t dbg_state_o
);

  vgacpu_pkg::line_state_t state_q;

  logic [7:0]         x0_q, y0_q, x1_q, y1_q;
  logic [D_WIDTH-1:0] col_q;
  logic signed [8:0]  x_q, y_q;
  logic signed [10:0] dx_q, dy_q, err_q;
  logic               sx_neg_q, sy_neg_q;

  logic               busy_q, done_q, we_q;
  logic [A_WIDTH-1:0] addr_q;
  logic [D_WIDTH-1:0] pix_q;

  logic [7:0]         abs_dx, abs_dy;
  logic signed [10:0] setup_dx, setup_dy;
  logic signed [10:0] e2, err_d;
  logic signed [8:0]  x_d, y_d;
  logic               at_end;
  logic               pt_visible;
  vgacpu_pkg::fb_addr_t pt_addr;

  fb_addr_calc u_addr (
    .x_i    (x_q),
    .y_i    (y_q),
    .addr_o (pt_addr)
  );

  always_comb begin
    abs_dx   = (x1_q > x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    abs_dy   = (y1_q > y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    setup_dx = $signed({3'b000, abs_dx});
    setup_dy = -$signed({3'b000, abs_dy});

    // Both axis updates are decided from the pre-step error term.
    e2    = err_q <<< 1;
    err_d = err_q;
    x_d   = x_q;
    y_d   = y_q;
    if (e2 >= dy_q) begin
      err_d = err_d + dy_q;
      x_d   = sx_neg_q ? (x_q - 9'sd1) : (x_q + 9'sd1);
    end
    if (e2 <= dx_q) begin
      err_d = err_d + dx_q;
      y_d   = sy_neg_q ? (y_q - 9'sd1) : (y_q + 9'sd1);
    end

    at_end = (x_q == $signed({1'b0, x1_q})) && (y_q == $signed({1'b0, y1_q}));

`ifdef FB_LINE_DRAWER_CLIP_EN
    pt_visible = !x_q[8] && !y_q[8]
              && ({2'b00, x_q[7:0]} < 10'(FB_WIDTH))
              && ({2'b00, y_q[7:0]} < 10'(FB_HEIGHT));
`else
    pt_visible = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q  <= vgacpu_pkg::IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      col_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      pix_q    <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        vgacpu_pkg::IDLE: begin
          if (start) begin
            x0_q    <= x0;
            y0_q    <= y0;
            x1_q    <= x1;
            y1_q    <= y1;
            col_q   <= colour;
            busy_q  <= 1'b1;
            state_q <= vgacpu_pkg::SETUP;
          end
        end
        vgacpu_pkg::SETUP: begin
          dx_q     <= setup_dx;
          dy_q     <= setup_dy;
          err_q    <= setup_dx + setup_dy;
          sx_neg_q <= !(x0_q < x1_q);
          sy_neg_q <= !(y0_q < y1_q);
          x_q      <= $signed({1'b0, x0_q});
          y_q      <= $signed({1'b0, y0_q});
          state_q  <= vgacpu_pkg::DRAW;
        end
        vgacpu_pkg::DRAW: begin
          we_q   <= pt_visible;
          addr_q <= A_WIDTH'(pt_addr);
          pix_q  <= col_q;
          if (at_end) begin
            state_q <= vgacpu_pkg::DONE;
          end else begin
            err_q <= err_d;
            x_q   <= x_d;
            y_q   <= y_d;
          end
        end
        vgacpu_pkg::DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= vgacpu_pkg::IDLE;
        end
        default: state_q <= vgacpu_pkg::IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign fb_write_en = we_q;
  assign fb_addr     = addr_q;
  assign fb_pixel    = pix_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fb_line_drawer.sv
// Randomized scoreboard bench for fb_line_drawer: a driver issues line commands and
// pushes expected writes/done pulses; a monitor pops and compares them as they appear.
module tb_fb_line_drawer;
  import vgacpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_async;
  logic        start;
  logic [7:0]  x0, y0, x1, y1;
  logic [2:0]  colour;
  logic        busy, done, fb_write_en;
  logic [15:0] fb_addr;
  logic [2:0]  fb_pixel;
  line_state_t dbg_state;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  logic [18:0] exp_q[$];
  int          exp_cyc_q[$];
  int          done_cyc_q[$];

  fb_line_drawer dut (
    .clk         (clk),
    .rst_async   (rst_async),
    .start       (start),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .colour      (colour),
    .busy        (busy),
    .done        (done),
    .fb_addr     (fb_addr),
    .fb_write_en (fb_write_en),
    .fb_pixel    (fb_pixel),
    .dbg_state_o (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // reference model
  task automatic push_write(input int x, input int y, input int col, input int c);
    exp_q.push_back({16'(y * 214 + x), 3'(col)});
    exp_cyc_q.push_back(c);
  endtask

  task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int col, input int s, output int n);
    int x, y, dx, dy, sx, sy, err, e2, k;
    dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx  = (ax0 < ax1) ? 1 : -1;
    sy  = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    x   = ax0;
    y   = ay0;
    k   = 0;
    forever begin
`ifdef FB_LINE_DRAWER_CLIP_EN
      if (x >= 0 && x < 214 && y >= 0 && y < 160) push_write(x, y, col, s + 3 + k);
`else
      push_write(x, y, col, s + 3 + k);
`endif
      k++;
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    // length derived independently from the endpoint spans
    n = ((dx > -dy) ? dx : -dy) + 1;
    done_cyc_q.push_back(s + 3 + n);
  endtask

  // driver
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int col, input int gap, input bit poke);
    int s, n;
    x0 = 8'(ax0); y0 = 8'(ay0); x1 = 8'(ax1); y1 = 8'(ay1); colour = 3'(col);
    start = 1'b1;
    s = cyc;
    model_line(ax0, ay0, ax1, ay1, col, s, n);
    @(negedge clk);
    start = 1'b0;
    x0 = 8'($urandom); y0 = 8'($urandom); x1 = 8'($urandom); y1 = 8'($urandom);
    colour = 3'($urandom);
    if (poke) begin
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (cyc <= s + n + 2) begin
        while (cyc < s + n + 2) @(negedge clk);
        start = 1'b1;
        x0 = 8'($urandom); y1 = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
    end
    while (cyc < s + n + 3 + gap) @(negedge clk);
    if (gap > 0) begin
      check("idle_busy", int'(busy), 0);
      check("idle_state", int'(dbg_state), int'(IDLE));
    end
  endtask

  task automatic reset_mid_line();
    int s, n;
    x0 = 8'd0; y0 = 8'd0; x1 = 8'd9; y1 = 8'd0; colour = 3'd6;
    start = 1'b1;
    s = cyc;
    model_line(0, 0, 9, 0, 6, s, n);
    @(negedge clk);
    start = 1'b0;
    while (cyc < s + 3) @(negedge clk);
    @(posedge clk);
    #2;
    check("pre_reset_we", int'(fb_write_en), 1);
    check("pre_reset_addr", int'(fb_addr), 1);
    rst_async = 1'b1;
    #1;
    exp_q.delete();
    exp_cyc_q.delete();
    done_cyc_q.delete();
    check("rst_we", int'(fb_write_en), 0);
    check("rst_addr", int'(fb_addr), 0);
    check("rst_pixel", int'(fb_pixel), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    @(negedge clk);
    rst_async = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_state", int'(dbg_state), int'(IDLE));
    check("post_rst_busy", int'(busy), 0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [18:0] e;
    int c;
    if (!rst_async) begin
      if (fb_write_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", int'(fb_addr), -1);
        end else begin
          e = exp_q.pop_front();
          c = exp_cyc_q.pop_front();
          check("write_addr", int'(fb_addr), int'(e[18:3]));
          check("write_pixel", int'(fb_pixel), int'(e[2:0]));
          check("write_cycle", cyc, c);
          check("busy_in_write", int'(busy), 1);
        end
      end
      if (done) begin
        if (done_cyc_q.size() == 0) check("unexpected_done", cyc, -1);
        else check("done_cycle", cyc, done_cyc_q.pop_front());
      end
    end
  end

  initial begin
    rst_async = 1'b1;
    start = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; colour = '0;
    repeat (2) @(negedge clk);
    check("reset_we", int'(fb_write_en), 0);
    check("reset_addr", int'(fb_addr), 0);
    check("reset_pixel", int'(fb_pixel), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_state", int'(dbg_state), int'(IDLE));
    rst_async = 1'b0;
    @(negedge clk);

    run_line(0, 0, 3, 0, 5, 1, 1'b0);
    run_line(10, 2, 10, 4, 2, 1, 1'b0);
    run_line(3, 3, 0, 0, 7, 1, 1'b0);
    run_line(213, 159, 213, 159, 1, 1, 1'b0);
    run_line(0, 0, 9, 4, 3, 0, 1'b1);
    run_line(212, 0, 215, 0, 4, 2, 1'b0);
    run_line(255, 255, 0, 0, 6, 1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      run_line(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
               ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 20; i++) begin
      int bx, by;
      bx = int'($urandom_range(0, 200));
      by = int'($urandom_range(0, 150));
      run_line(bx, by, bx + int'($urandom_range(0, 13)), by + int'($urandom_range(0, 9)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'b0);
    end

    reset_mid_line();
    run_line(5, 7, 1, 9, 5, 2, 1'b0);

    check("exp_writes_drained", exp_q.size(), 0);
    check("exp_done_drained", done_cyc_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
